// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner.
// Rotates a single active-low column strobe, samples the synchronized rows
// once per column slot, classifies each full scan as none/single/multi,
// debounces over DEBOUNCE_SCANS identical scans, and reports new key presses.
// Optional build macro: KEYPAD_DIGIT_MAP_EN -- when defined, key_code is the
// printed keypad legend; otherwise key_code is {row index, column index}.
module keypad_scan #(
    parameter int SCAN_DIV       = 5,   // clock cycles per column slot, 4..255
    parameter int DEBOUNCE_SCANS = 1    // identical scans before acceptance, 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       multi_key
);

    localparam logic [7:0] SLOT_LAST     = 8'(SCAN_DIV - 1);
    localparam logic [3:0] STABLE_TARGET = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        COL_0,
        COL_1,
        COL_2,
        COL_3
    } col_state_e;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } res_kind_e;

    // Position fields are only meaningful for RES_SINGLE and are kept zero
    // otherwise, so whole-struct equality compares scan results directly.
    typedef struct packed {
        res_kind_e  kind;
        logic [1:0] r;
        logic [1:0] c;
    } scan_res_t;

    localparam scan_res_t RES_IDLE = '{kind: RES_NONE, r: 2'd0, c: 2'd0};

    // Translate a (row, column) position into the reported key code.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
`ifdef KEYPAD_DIGIT_MAP_EN
        case ({r, c})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
`else
        code = {r, c};
`endif
        return code;
    endfunction

    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;

    logic [7:0]       slot_q, slot_d;
    col_state_e       col_state_q, col_state_d;
    logic [2:0][3:0]  samp_q, samp_d;      // rows captured for columns 0..2

    logic [3:0][3:0]  grid;                // full scan, grid[c] = rows of column c
    logic [4:0]       n_low;
    logic [1:0]       pos_r, pos_c;
    scan_res_t        scan_res;

    logic [3:0]       stab_q, stab_d;
    scan_res_t        prev_q, prev_d;
    scan_res_t        acc_q, acc_d;

    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_held_q, key_held_d;
    logic             multi_key_q, multi_key_d;

    logic             sample_edge;
    logic             scan_end;

    assign sample_edge = (slot_q == SLOT_LAST);
    assign scan_end    = sample_edge && (col_state_q == COL_3);

    // Two-flop synchronizer for the asynchronous row lines; idles at "no key".
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            // NOTE: non-blocking assignments make both flops load the value
            // present before the edge, giving a true two-stage delay.
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Column rotation FSM: slot timing, column advance and per-column capture.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves a signal unassigned and no latch is inferred.
        slot_d      = slot_q + 8'd1;
        col_state_d = col_state_q;
        samp_d      = samp_q;
        if (sample_edge) begin
            slot_d = 8'd0;
            case (col_state_q)
                COL_0: begin
                    samp_d[0]   = row_sync_q;
                    col_state_d = COL_1;
                end
                COL_1: begin
                    samp_d[1]   = row_sync_q;
                    col_state_d = COL_2;
                end
                COL_2: begin
                    samp_d[2]   = row_sync_q;
                    col_state_d = COL_3;
                end
                default: begin
                    col_state_d = COL_0;
                end
            endcase
        end
    end

    // Drive exactly one active-low column line for the current column state.
    always_comb begin
        case (col_state_q)
            COL_0:   col = 4'b0111;
            COL_1:   col = 4'b1011;
            COL_2:   col = 4'b1101;
            default: col = 4'b1110;
        endcase
    end

    // Classify the full scan; column 3 is taken live from the synchronizer
    // because its sample is being captured on this very edge.
    always_comb begin
        grid[0]  = samp_q[0];
        grid[1]  = samp_q[1];
        grid[2]  = samp_q[2];
        grid[3]  = row_sync_q;
        n_low    = 5'd0;
        pos_r    = 2'd0;
        pos_c    = 2'd0;
        scan_res = RES_IDLE;
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (!grid[c][b]) begin
                    n_low = n_low + 5'd1;
                    pos_r = 2'(3 - b);      // row bit 3 is row index 0
                    pos_c = 2'(c);
                end
            end
        end
        if (n_low == 5'd1) begin
            scan_res = '{kind: RES_SINGLE, r: pos_r, c: pos_c};
        end else if (n_low > 5'd1) begin
            scan_res.kind = RES_MULTI;
        end
    end

    // Debounce over consecutive scans and derive the key reporting outputs.
    always_comb begin
        stab_d      = stab_q;
        prev_d      = prev_q;
        acc_d       = acc_q;
        key_valid_d = 1'b0;
        multi_key_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        if (scan_end) begin
            prev_d = scan_res;
            if (scan_res != prev_q) begin
                stab_d = 4'd1;
            end else if (stab_q < STABLE_TARGET) begin
                stab_d = stab_q + 4'd1;
            end

            if (stab_d == STABLE_TARGET) begin
                case (scan_res.kind)
                    RES_SINGLE: begin
                        key_held_d = 1'b1;
                        // Any change of accepted result, including from
                        // none/multi or from another key, reports a press.
                        if (acc_q != scan_res) begin
                            key_valid_d = 1'b1;
                            key_code_d  = key_map(scan_res.r, scan_res.c);
                        end
                    end
                    RES_MULTI: begin
                        key_held_d = 1'b0;
                        if (acc_q.kind != RES_MULTI) begin
                            multi_key_d = 1'b1;
                        end
                    end
                    default: begin
                        key_held_d = 1'b0;
                    end
                endcase
                acc_d = scan_res;
            end
        end
    end

    // State and output registers; reset aborts any scan in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= 8'd0;
            col_state_q <= COL_0;
            // NOTE: the sample bank is reset on purpose so a scan aborted by
            // reset can never leak stale column data into the next result.
            samp_q      <= '1;
            stab_q      <= 4'd0;
            prev_q      <= RES_IDLE;
            acc_q       <= RES_IDLE;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
            multi_key_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            col_state_q <= col_state_d;
            samp_q      <= samp_d;
            stab_q      <= stab_d;
            prev_q      <= prev_d;
            acc_q       <= acc_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            multi_key_q <= multi_key_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: self-checking bench for keypad_scan.
// Two scanners share one simulated keypad: dut_a debounces over 1 scan and
// dut_b over 3 scans. The keypad is a 16-bit set of pressed keys (bit r*4+c)
// that changes only at scan boundaries; a reference model classifies each
// scan from the key set and applies the press/hold/multi rules.
module tb_keypad_scan;

    localparam int SCAN_DIV = 5;
    localparam int SCAN_CYC = 4 * SCAN_DIV;
    localparam int R_NONE   = -1;
    localparam int R_MULTI  = -2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keys;

    logic [3:0]  row_a, col_a, code_a;
    logic [3:0]  row_b, col_b, code_b;
    logic        kv_a, held_a, mk_a;
    logic        kv_b, held_b, mk_b;

    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state: shared scan history, per-scanner accepted state.
    int          hist[$];
    int          dbn[2];
    int          acc[2];
    logic [3:0]  e_code[2];
    logic        e_held[2];
    logic        e_kv[2];
    logic        e_mk[2];

    logic [15:0] rk;
    int          p;
    int          a_bit, b_bit;

    always #5 clk = ~clk;

    // Rows seen by a scanner: a row line is pulled low when a pressed key
    // joins it to the currently driven (low) column.
    function automatic logic [3:0] pad_rows(input logic [15:0] k, input logic [3:0] c_lines);
        logic [3:0] r;
        r = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (c_lines[3-c] == 1'b0) begin
                for (int ri = 0; ri < 4; ri++) begin
                    if (k[ri*4+c]) r[3-ri] = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign row_a = pad_rows(keys, col_a);
    assign row_b = pad_rows(keys, col_b);

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .row       (row_a),
        .col       (col_a),
        .key_valid (kv_a),
        .key_code  (code_a),
        .key_held  (held_a),
        .multi_key (mk_a)
    );

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .row       (row_b),
        .col       (col_b),
        .key_valid (kv_b),
        .key_code  (code_b),
        .key_held  (held_b),
        .multi_key (mk_b)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] col_pattern(input int idx);
        logic [3:0] one_hot;
        one_hot = 4'b1000 >> idx;
        return ~one_hot;
    endfunction

    // Printed legend (or plain position) for key position r*4+c.
    function automatic logic [3:0] legend(input int pos);
        logic [3:0] v;
`ifdef KEYPAD_DIGIT_MAP_EN
        case (pos)
            0:       v = 4'h1;
            1:       v = 4'h2;
            2:       v = 4'h3;
            3:       v = 4'hA;
            4:       v = 4'h4;
            5:       v = 4'h5;
            6:       v = 4'h6;
            7:       v = 4'hB;
            8:       v = 4'h7;
            9:       v = 4'h8;
            10:      v = 4'h9;
            11:      v = 4'hC;
            12:      v = 4'hE;
            13:      v = 4'h0;
            14:      v = 4'hF;
            default: v = 4'hD;
        endcase
`else
        v = 4'(pos);
`endif
        return v;
    endfunction

    function automatic int classify(input logic [15:0] k);
        int n;
        n = $countones(k);
        if (n == 0) return R_NONE;
        if (n > 1) return R_MULTI;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) return i;
        end
        return R_NONE;
    endfunction

    // True when the last n scan results since reset are all identical.
    function automatic bit stable(input int n);
        int last;
        if (hist.size() < n) return 1'b0;
        last = hist[hist.size()-1];
        for (int j = 1; j < n; j++) begin
            if (hist[hist.size()-1-j] != last) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int d = 0; d < 2; d++) begin
            acc[d]    = R_NONE;
            e_code[d] = 4'h0;
            e_held[d] = 1'b0;
            e_kv[d]   = 1'b0;
            e_mk[d]   = 1'b0;
        end
    endtask

    task automatic model_scan(input int res);
        hist.push_back(res);
        if (hist.size() > 16) void'(hist.pop_front());
        for (int d = 0; d < 2; d++) begin
            e_kv[d] = 1'b0;
            e_mk[d] = 1'b0;
            if (stable(dbn[d])) begin
                if (res >= 0) begin
                    if (acc[d] != res) begin
                        e_kv[d]   = 1'b1;
                        e_code[d] = legend(res);
                    end
                    e_held[d] = 1'b1;
                end else begin
                    e_held[d] = 1'b0;
                    if (res == R_MULTI && acc[d] != R_MULTI) e_mk[d] = 1'b1;
                end
                acc[d] = res;
            end
        end
    endtask

    // One full scan with a fixed key set; checks rotation every cycle, that
    // no pulse appears mid-scan, and the outputs right after the scan ends.
    task automatic run_scan(input logic [15:0] k);
        int s_kv_a, s_kv_b, s_mk_a, s_mk_b;
        s_kv_a = 0; s_kv_b = 0; s_mk_a = 0; s_mk_b = 0;
        keys = k;
        for (int i = 1; i <= SCAN_CYC; i++) begin
            @(posedge clk);
            #1;
            check("col_a", col_a, col_pattern((i / SCAN_DIV) % 4));
            check("col_b", col_b, col_pattern((i / SCAN_DIV) % 4));
            if (i < SCAN_CYC) begin
                s_kv_a += int'(kv_a);
                s_kv_b += int'(kv_b);
                s_mk_a += int'(mk_a);
                s_mk_b += int'(mk_b);
            end
        end
        model_scan(classify(k));
        check("midscan_kv_a", 16'(s_kv_a), 16'd0);
        check("midscan_kv_b", 16'(s_kv_b), 16'd0);
        check("midscan_mk_a", 16'(s_mk_a), 16'd0);
        check("midscan_mk_b", 16'(s_mk_b), 16'd0);
        check("key_valid_a", kv_a,   e_kv[0]);
        check("key_valid_b", kv_b,   e_kv[1]);
        check("multi_key_a", mk_a,   e_mk[0]);
        check("multi_key_b", mk_b,   e_mk[1]);
        check("key_code_a",  code_a, e_code[0]);
        check("key_code_b",  code_b, e_code[1]);
        check("key_held_a",  held_a, e_held[0]);
        check("key_held_b",  held_b, e_held[1]);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_col_a"},  col_a,  4'b0111);
        check({tag, "_col_b"},  col_b,  4'b0111);
        check({tag, "_kv_a"},   kv_a,   1'b0);
        check({tag, "_kv_b"},   kv_b,   1'b0);
        check({tag, "_code_a"}, code_a, 4'h0);
        check({tag, "_code_b"}, code_b, 4'h0);
        check({tag, "_held_a"}, held_a, 1'b0);
        check({tag, "_held_b"}, held_b, 1'b0);
        check({tag, "_mk_a"},   mk_a,   1'b0);
        check({tag, "_mk_b"},   mk_b,   1'b0);
    endtask

    // Start a scan with key set k, assert reset after n_cyc cycles of it.
    task automatic abort_scan(input logic [15:0] k, input int n_cyc);
        keys = k;
        for (int i = 1; i <= n_cyc; i++) begin
            @(posedge clk);
            #1;
            check("abort_col_a", col_a, col_pattern((i / SCAN_DIV) % 4));
            check("abort_kv_a", kv_a, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_reset_state("abort");
    endtask

    initial begin
        dbn[0] = 1;
        dbn[1] = 3;
        rst    = 1'b1;
        keys   = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        // Keys 1, 2, 3 on consecutive scans, then idle.
        run_scan(16'h0001);
        run_scan(16'h0002);
        run_scan(16'h0004);
        repeat (3) run_scan(16'h0000);

        // Hold r0 c0 for five scans, release, press again.
        repeat (5) run_scan(16'h0001);
        repeat (3) run_scan(16'h0000);
        repeat (3) run_scan(16'h0001);
        repeat (3) run_scan(16'h0000);

        // Two keys in the same column row, then direct key-to-key change.
        repeat (3) run_scan(16'h0005);
        repeat (3) run_scan(16'h0000);
        repeat (3) run_scan(16'h0008);
        repeat (3) run_scan(16'h8000);

        // Bounce on r1 c1, then a clean three-scan press.
        repeat (2) begin
            run_scan(16'h0020);
            run_scan(16'h0000);
        end
        repeat (3) run_scan(16'h0020);
        repeat (3) run_scan(16'h0000);

        // Reset in the col-2 slot of a pending press; debounce restarts.
        repeat (2) run_scan(16'h0040);
        abort_scan(16'h0040, 2 * SCAN_DIV + 2);
        repeat (3) run_scan(16'h0040);
        abort_scan(16'h0400, 2 * SCAN_DIV + 3);
        run_scan(16'h0000);

        // All rows stuck low: one multi pulse, no key.
        repeat (4) run_scan(16'hFFFF);
        repeat (3) run_scan(16'h0000);

        // Random key activity with frequent repeats so debouncing completes.
        rk = 16'h0000;
        for (int s = 0; s < 60; s++) begin
            p = int'($urandom_range(99));
            if (p < 45) begin
                rk = rk;
            end else if (p < 65) begin
                rk = 16'h0000;
            end else if (p < 90) begin
                rk = 16'h0001 << $urandom_range(15);
            end else begin
                a_bit = int'($urandom_range(15));
                b_bit = int'($urandom_range(15));
                rk = (16'h0001 << a_bit) | (16'h0001 << b_bit);
            end
            run_scan(rk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
